id_stage: RTL and testbench

- Decode-side receiver for the fetch stage's {PC, Inst} bus.
- Accepts fetch packets over a valid/ready handshake into a 2-entry buffer and pre-decodes each instruction.
- Resolves direct jumps (B, BL) in decode and sends a one-cycle redirect (is_branch/flush/dnpc) back to fetch.
- Forwards a decoded bus to the execute stage over a second valid/ready handshake.

---
 rtl/id_stage_pkg.sv | 46 ++++
 rtl/id_decoder.sv | 52 +++++
 rtl/id_stage.sv | 109 ++++++++++
 tb/tb_id_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants, control-bit indices and decoded-entry layout for
// the decode stage and its pre-decoder.
package id_stage_pkg;

  localparam bit RestEn = 1'b1;

  localparam logic [5:0] OP_B     = 6'b010100;
  localparam logic [5:0] OP_BL    = 6'b010101;
  localparam logic [5:0] OP_JIRL  = 6'b010011;
  localparam logic [5:0] OP_BR_LO = 6'b010110;
  localparam logic [5:0] OP_BR_HI = 6'b011011;

  localparam logic [9:0] OP_LD_B   = 10'b0010100000;
  localparam logic [9:0] OP_LD_H   = 10'b0010100001;
  localparam logic [9:0] OP_LD_W   = 10'b0010100010;
  localparam logic [9:0] OP_ST_B   = 10'b0010100100;
  localparam logic [9:0] OP_ST_H   = 10'b0010100101;
  localparam logic [9:0] OP_ST_W   = 10'b0010100110;
  localparam logic [9:0] OP_ADDI_W = 10'b0000001010;

  localparam logic [6:0] OP_LU12I_W   = 7'b0001010;
  localparam logic [6:0] OP_PCADDU12I = 7'b0001110;

  localparam int CTRL_IS_B     = 0;
  localparam int CTRL_IS_BL    = 1;
  localparam int CTRL_IS_JIRL  = 2;
  localparam int CTRL_COND_BR  = 3;
  localparam int CTRL_IS_LOAD  = 4;
  localparam int CTRL_IS_STORE = 5;
  localparam int CTRL_INVALID  = 6;
  localparam int CTRL_RD_WE    = 7;

  localparam int ID_PC_LSB   = 72;
  localparam int ID_INST_LSB = 40;
  localparam int ID_IMM_LSB  = 8;
  localparam int ID_CTRL_LSB = 0;

  // Field order matches the id_bus layout, so an entry casts straight onto it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } id_entry_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational pre-decoder: classifies an instruction and extracts its
// sign-extended immediate.
module id_decoder
  import id_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o,
  output logic [7:0]  ctrl_o
);

  logic [5:0] op6;
  logic [6:0] op7;
  logic [9:0] op10;
  logic is_b, is_bl, is_jirl, cond_br, is_load, is_store;
  logic is_addi, is_lu12i, is_pcadd, invalid, rd_we;

  assign op6  = inst_i[31:26];
  assign op7  = inst_i[31:25];
  assign op10 = inst_i[31:22];

  assign is_b     = (op6 == OP_B);
  assign is_bl    = (op6 == OP_BL);
  assign is_jirl  = (op6 == OP_JIRL);
  assign cond_br  = (op6 >= OP_BR_LO) && (op6 <= OP_BR_HI);
  assign is_load  = op10 inside {OP_LD_B, OP_LD_H, OP_LD_W};
  assign is_store = op10 inside {OP_ST_B, OP_ST_H, OP_ST_W};
  assign is_addi  = (op10 == OP_ADDI_W);
  assign is_lu12i = (op7 == OP_LU12I_W);
  assign is_pcadd = (op7 == OP_PCADDU12I);

  assign invalid = ~(is_b | is_bl | is_jirl | cond_br | is_load | is_store |
                     is_addi | is_lu12i | is_pcadd);
  // Branches without a link and stores never write a register.
  assign rd_we   = is_bl | is_jirl | is_load | is_addi | is_lu12i | is_pcadd;

  assign ctrl_o = {rd_we, invalid, is_store, is_load, cond_br, is_jirl, is_bl, is_b};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    imm_o = '0;
    if (is_b | is_bl) begin
      imm_o = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};
    end else if (cond_br | is_jirl) begin
      imm_o = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
    end else if (is_addi | is_load | is_store) begin
      imm_o = {{20{inst_i[21]}}, inst_i[21:10]};
    end else if (is_lu12i | is_pcadd) begin
      imm_o = {inst_i[24:5], 12'b0};
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: 2-entry pre-decoded buffer between fetch and execute, with
// direct-jump (B/BL) resolution and a one-cycle redirect back to fetch.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1C000000,
  parameter int          ID_BUS_W = 104
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [63:0]         if_bus,
  output logic                is_branch,
  output logic                flush,
  output logic [31:0]         dnpc,
  input  logic                ex_flush,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [ID_BUS_W-1:0] id_bus
);

  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic        redir_q, redir_d;
  logic [31:0] dnpc_q, dnpc_d;
  id_entry_t   mem_q [2];
  id_entry_t   new_entry;
  logic        mem_we;
  logic        push, pop;
  logic [31:0] dec_imm;
  logic [7:0]  dec_ctrl;

  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  id_decoder u_dec (
    .inst_i (if_bus[31:0]),
    .imm_o  (dec_imm),
    .ctrl_o (dec_ctrl)
  );

  assign new_entry = '{pc: if_bus[63:32], inst: if_bus[31:0], imm: dec_imm, ctrl: dec_ctrl};

  // Ready is register-only (plus reset) so execute's id_ready never reaches fetch.
  assign if_ready  = ~reset & (count_q < 2'd2) & ~redir_q;
  assign id_valid  = ~reset & (count_q != 2'd0);
  assign id_bus    = id_valid ? ID_BUS_W'(mem_q[head_q]) : '0;
  assign is_branch = ~reset & redir_q & ~ex_flush;
  assign flush     = is_branch;
  assign dnpc      = reset ? '0 : dnpc_q;

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    redir_d = 1'b0;
    dnpc_d  = dnpc_q;
    mem_we  = 1'b0;
    if (ex_flush) begin
      count_d = '0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) begin
        mem_we = 1'b1;
        tail_d = ~tail_q;
        if (dec_ctrl[CTRL_IS_B] | dec_ctrl[CTRL_IS_BL]) begin
          redir_d = 1'b1;
          dnpc_d  = if_bus[63:32] + dec_imm;
        end
      end
      if (pop) head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (RestEn && reset) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      redir_q <= 1'b0;
      dnpc_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      redir_q <= redir_d;
      dnpc_q  <= dnpc_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_q] <= new_entry;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected decoded entries go into a scoreboard
// queue that a negedge monitor drains on every id_valid & id_ready.
module tb_id_stage;
  import id_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_valid;
  logic         if_ready;
  logic [63:0]  if_bus;
  logic         is_branch;
  logic         flush;
  logic [31:0]  dnpc;
  logic         ex_flush;
  logic         id_valid;
  logic         id_ready;
  logic [103:0] id_bus;

  int n_checks = 0;
  int n_fail   = 0;
  id_entry_t exp_q[$];
  id_entry_t mon_e;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC(32'h1C000000), .ID_BUS_W(104)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_bus    (if_bus),
    .is_branch (is_branch),
    .flush     (flush),
    .dnpc      (dnpc),
    .ex_flush  (ex_flush),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_bus    (id_bus)
  );

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one packet until accepted (bounded), records its expected entry,
  // and returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] imm, input logic [7:0] ctrl);
    bit ok = 0;
    if_valid = 1'b1;
    if_bus   = {pc, inst};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ready) begin
        exp_q.push_back('{pc: pc, inst: inst, imm: imm, ctrl: ctrl});
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    step();
    if_valid = 1'b0;
    if_bus   = '0;
  endtask

  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", id_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("id_bus", id_bus, mon_e);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    if_valid = 1'b1;
    if_bus   = {32'h1C000000, 32'h02BFFC01};
    id_ready = 1'b1;
    ex_flush = 1'b0;
    step();
    @(negedge clk);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_is_branch", is_branch, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_if_ready", if_ready, 1'b0);
    check("rst_dnpc", dnpc, 32'h0);
    check("rst_id_bus", id_bus, '0);
    step();
    reset    = 1'b0;
    if_valid = 1'b0;
    if_bus   = '0;
    @(negedge clk);
    check("post_rst_if_ready", if_ready, 1'b1);
    step();

    // addi.w r1,r0,-1
    send(32'h1C000000, 32'h02BFFC01, 32'hFFFFFFFF, 8'h80);
    @(negedge clk);
    check("addi_latency", id_valid, 1'b1);
    step();

    // B +8: redirect pulse for exactly one cycle
    send(32'h1C000000, 32'h50000800, 32'h00000008, 8'h01);
    @(negedge clk);
    check("b_is_branch", is_branch, 1'b1);
    check("b_flush", flush, 1'b1);
    check("b_dnpc", dnpc, 32'h1C000008);
    check("b_if_ready", if_ready, 1'b0);
    @(negedge clk);
    check("b_pulse_end", is_branch, 1'b0);
    check("b_if_ready_back", if_ready, 1'b1);
    check("b_dnpc_hold", dnpc, 32'h1C000008);
    step();

    // BL -4: backward offset wraps
    send(32'h1C000010, 32'h57FFFFFF, 32'hFFFFFFFC, 8'h82);
    @(negedge clk);
    check("bl_is_branch", is_branch, 1'b1);
    check("bl_dnpc", dnpc, 32'h1C00000C);
    step();

    // Backpressure: two accepted, third held until a slot frees
    id_ready = 1'b0;
    send(32'h1C000020, 32'h02800421, 32'h00000001, 8'h80);
    send(32'h1C000024, 32'h02801042, 32'h00000004, 8'h80);
    if_valid = 1'b1;
    if_bus   = {32'h1C000028, 32'h02BFF863};
    @(negedge clk);
    check("full_if_ready", if_ready, 1'b0);
    check("full_id_valid", id_valid, 1'b1);
    step();
    id_ready = 1'b1;
    send(32'h1C000028, 32'h02BFF863, 32'hFFFFFFFE, 8'h80);

    // Remaining decode classes
    send(32'h1C000030, 32'h28802085, 32'h00000008, 8'h90); // ld.w
    send(32'h1C000034, 32'h29BFF085, 32'hFFFFFFFC, 8'h20); // st.w
    send(32'h1C000038, 32'h142468A3, 32'h12345000, 8'h80); // lu12i.w
    send(32'h1C00003C, 32'h1C000024, 32'h00001000, 8'h80); // pcaddu12i
    send(32'h1C000040, 32'h4FFFFC20, 32'hFFFFFFFC, 8'h84); // jirl
    send(32'h1C000044, 32'h58001000, 32'h00000010, 8'h08); // beq
    send(32'h1C000048, 32'hFFFFFFFF, 32'h00000000, 8'h40); // invalid
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    step();

    // ex_flush in the redirect cycle suppresses the pulse and empties decode
    id_ready = 1'b0;
    send(32'h1C000050, 32'h50000800, 32'h00000008, 8'h01);
    ex_flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("exf_is_branch", is_branch, 1'b0);
    check("exf_flush", flush, 1'b0);
    step();
    ex_flush = 1'b0;
    @(negedge clk);
    check("exf_id_valid", id_valid, 1'b0);
    check("exf_if_ready", if_ready, 1'b1);
    step();

    // A push coinciding with ex_flush is discarded
    if_valid = 1'b1;
    if_bus   = {32'h1C000060, 32'h02800421};
    ex_flush = 1'b1;
    @(negedge clk);
    check("exf_push_offered", if_ready, 1'b1);
    step();
    if_valid = 1'b0;
    ex_flush = 1'b0;
    @(negedge clk);
    check("exf_push_dropped", id_valid, 1'b0);
    step();

    // Reset mid-operation empties the buffer
    send(32'h1C000070, 32'h02800421, 32'h00000001, 8'h80);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_id_valid", id_valid, 1'b0);
    check("midrst_id_bus", id_bus, '0);
    step();
    reset    = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    check("midrst_empty", id_valid, 1'b0);
    check("midrst_if_ready", if_ready, 1'b1);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
